// File: rtl/key_event_ctrl.sv
// key_event_ctrl: per-key press / long-press / auto-repeat event generator.
// Debounced key levels (0 = pressed) drive one small FSM per key, all timed
// from a shared tick prescaler. Each key owns a one-deep pending slot, and a
// round-robin arbiter moves the pending events onto one valid/ready port.
module key_event_ctrl #(
    parameter int NUM_KEYS     = 4,
    parameter int KEY_W        = 2,
    parameter int TICK_DIV     = 50000,
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int TMR_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_lvl,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [KEY_W-1:0]    ev_key,
    output logic [1:0]          ev_code,
    output logic [NUM_KEYS-1:0] key_down,
    output logic [NUM_KEYS-1:0] ovf,
    input  logic                clr_ovf
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] EV_PRESS   = 2'b00;
    localparam logic [1:0] EV_LONG    = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DOWN = 2'b01,
        ST_HOLD = 2'b10
    } key_st_e;

    // Edge detection
    logic [NUM_KEYS-1:0] prev_lvl_q;
    logic [NUM_KEYS-1:0] press_edge;
    logic [NUM_KEYS-1:0] release_edge;

    // Prescaler
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    // Per-key FSMs and timers
    key_st_e         st_q  [NUM_KEYS];
    key_st_e         st_d  [NUM_KEYS];
    logic [TMR_W-1:0] tmr_q [NUM_KEYS];
    logic [TMR_W-1:0] tmr_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] emit;
    logic [1:0]          emit_code [NUM_KEYS];

    // Pending slots and overflow flags
    logic [NUM_KEYS-1:0] pend_q, pend_d;
    logic [1:0]          pcode_q [NUM_KEYS];
    logic [1:0]          pcode_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] ovf_q, ovf_d;

    // Arbiter and output register
    logic                load;
    logic                grant_vld;
    int                  gidx;
    int                  idx;
    logic [NUM_KEYS-1:0] drain;
    logic                ev_valid_q, ev_valid_d;
    logic [KEY_W-1:0]    ev_key_q, ev_key_d;
    logic [1:0]          ev_code_q, ev_code_d;
    logic [KEY_W-1:0]    rr_last_q, rr_last_d;

    assign press_edge   = prev_lvl_q & ~key_lvl;
    assign release_edge = ~prev_lvl_q & key_lvl;

    // Free-running prescaler; tick marks the last count of each period
    always_comb begin
        tick    = (presc_q == PW'(TICK_DIV - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Per-key next state: release beats a same-cycle timer expiry
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            st_d[i]      = st_q[i];
            tmr_d[i]     = tmr_q[i];
            emit[i]      = 1'b0;
            emit_code[i] = EV_PRESS;
            case (st_q[i])
                ST_IDLE: begin
                    if (press_edge[i]) begin
                        st_d[i]      = ST_DOWN;
                        tmr_d[i]     = '0;
                        emit[i]      = 1'b1;
                        emit_code[i] = EV_PRESS;
                    end
                end
                ST_DOWN: begin
                    if (release_edge[i]) begin
                        st_d[i]      = ST_IDLE;
                        tmr_d[i]     = '0;
                        emit[i]      = 1'b1;
                        emit_code[i] = EV_RELEASE;
                    end else if (tick) begin
                        if (tmr_q[i] == TMR_W'(LONG_TICKS - 1)) begin
                            st_d[i]      = ST_HOLD;
                            tmr_d[i]     = '0;
                            emit[i]      = 1'b1;
                            emit_code[i] = EV_LONG;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (release_edge[i]) begin
                        st_d[i]      = ST_IDLE;
                        tmr_d[i]     = '0;
                        emit[i]      = 1'b1;
                        emit_code[i] = EV_RELEASE;
                    end else if (tick) begin
                        if (tmr_q[i] == TMR_W'(REPEAT_TICKS - 1)) begin
                            tmr_d[i]     = '0;
                            emit[i]      = 1'b1;
                            emit_code[i] = EV_REPEAT;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    st_d[i]  = ST_IDLE;
                    tmr_d[i] = '0;
                end
            endcase
        end
    end

    // Round-robin grant starting after the last served key; load output register
    always_comb begin
        load       = !ev_valid_q || ev_ready;
        grant_vld  = 1'b0;
        gidx       = 0;
        idx        = 0;
        drain      = '0;
        ev_valid_d = ev_valid_q;
        ev_key_d   = ev_key_q;
        ev_code_d  = ev_code_q;
        rr_last_d  = rr_last_q;
        for (int j = 1; j <= NUM_KEYS; j++) begin
            idx = (int'(rr_last_q) + j) % NUM_KEYS;
            if (!grant_vld && pend_q[idx]) begin
                grant_vld = 1'b1;
                gidx      = idx;
            end
        end
        if (load) begin
            if (grant_vld) begin
                ev_valid_d  = 1'b1;
                ev_key_d    = KEY_W'(gidx);
                ev_code_d   = pcode_q[gidx];
                rr_last_d   = KEY_W'(gidx);
                drain[gidx] = 1'b1;
            end else begin
                ev_valid_d = 1'b0;
            end
        end
    end

    // Pending slot update: a full, undrained slot keeps its event unless the
    // new one is RELEASE, which must never be lost; either way flag overflow
    always_comb begin
        ovf_d = clr_ovf ? '0 : ovf_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            pend_d[i]  = pend_q[i];
            pcode_d[i] = pcode_q[i];
            if (emit[i]) begin
                if (pend_q[i] && !drain[i]) begin
                    ovf_d[i] = 1'b1;
                    if (emit_code[i] == EV_RELEASE) begin
                        pcode_d[i] = EV_RELEASE;
                    end
                end else begin
                    pend_d[i]  = 1'b1;
                    pcode_d[i] = emit_code[i];
                end
            end else if (drain[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // State registers; prev_lvl resets high so a key held through reset presses
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_lvl_q <= '1;
            presc_q    <= '0;
            pend_q     <= '0;
            ovf_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            ev_code_q  <= '0;
            rr_last_q  <= KEY_W'(NUM_KEYS - 1);
            for (int i = 0; i < NUM_KEYS; i++) begin
                st_q[i]    <= ST_IDLE;
                tmr_q[i]   <= '0;
                pcode_q[i] <= '0;
            end
        end else begin
            prev_lvl_q <= key_lvl;
            presc_q    <= presc_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            ev_code_q  <= ev_code_d;
            rr_last_q  <= rr_last_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                st_q[i]    <= st_d[i];
                tmr_q[i]   <= tmr_d[i];
                pcode_q[i] <= pcode_d[i];
            end
        end
    end

    // Key is reported down whenever its FSM has left IDLE
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            key_down[i] = (st_q[i] != ST_IDLE);
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_key   = ev_key_q;
    assign ev_code  = ev_code_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random key/ready traffic,
// all checked cycle by cycle against a tick-counting reference model.
module tb_key_event_ctrl;

    localparam int NK     = 4;
    localparam int KW     = 2;
    localparam int TDIV   = 4;
    localparam int LONG   = 3;
    localparam int REPEAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_lvl;
    logic          ev_valid;
    logic          ev_ready;
    logic [KW-1:0] ev_key;
    logic [1:0]    ev_code;
    logic [NK-1:0] key_down;
    logic [NK-1:0] ovf;
    logic          clr_ovf;

    key_event_ctrl #(
        .NUM_KEYS(NK), .KEY_W(KW), .TICK_DIV(TDIV),
        .LONG_TICKS(LONG), .REPEAT_TICKS(REPEAT), .TMR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .key_lvl(key_lvl),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key), .ev_code(ev_code),
        .key_down(key_down), .ovf(ovf), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_hs  = 0;

    typedef struct {
        int key;
        int code;
        int cyc;
    } ev_t;
    ev_t log_q[$];

    // Reference model: ticks counted since the press, events by arithmetic
    logic [NK-1:0] m_prev, m_down, m_pend, m_ovf;
    int            m_ticks [NK];
    int            m_pcode [NK];
    int            m_presc;
    logic          m_valid;
    int            m_key, m_code, m_rr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_prev  = '1;
        m_down  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_presc = 0;
        m_valid = 1'b0;
        m_key   = 0;
        m_code  = 0;
        m_rr    = NK - 1;
        for (int k = 0; k < NK; k++) begin
            m_ticks[k] = 0;
            m_pcode[k] = 0;
        end
    endtask

    task automatic m_step();
        bit tick, load, gv, cur, drained;
        bit em [NK];
        int ec [NK];
        int g, ix;
        if (rst) begin
            m_reset();
            return;
        end
        tick    = (m_presc == TDIV - 1);
        m_presc = tick ? 0 : m_presc + 1;
        for (int k = 0; k < NK; k++) begin
            em[k] = 0;
            ec[k] = 0;
            cur   = key_lvl[k];
            if (!m_down[k]) begin
                if (m_prev[k] && !cur) begin
                    m_down[k] = 1; m_ticks[k] = 0; em[k] = 1; ec[k] = 0;
                end
            end else if (!m_prev[k] && cur) begin
                m_down[k] = 0; em[k] = 1; ec[k] = 3;
            end else if (tick) begin
                m_ticks[k]++;
                if (m_ticks[k] == LONG) begin
                    em[k] = 1; ec[k] = 1;
                end else if (m_ticks[k] > LONG && ((m_ticks[k] - LONG) % REPEAT) == 0) begin
                    em[k] = 1; ec[k] = 2;
                end
            end
            m_prev[k] = cur;
        end
        load = !m_valid || ev_ready;
        gv   = 0;
        g    = 0;
        for (int j = 1; j <= NK; j++) begin
            ix = (m_rr + j) % NK;
            if (!gv && m_pend[ix]) begin
                gv = 1; g = ix;
            end
        end
        if (load) begin
            if (gv) begin
                m_valid = 1; m_key = g; m_code = m_pcode[g]; m_rr = g;
            end else begin
                m_valid = 0;
            end
        end
        if (clr_ovf) m_ovf = '0;
        for (int k = 0; k < NK; k++) begin
            drained = load && gv && (g == k);
            if (em[k]) begin
                if (m_pend[k] && !drained) begin
                    m_ovf[k] = 1;
                    if (ec[k] == 3) m_pcode[k] = 3;
                end else begin
                    m_pend[k] = 1; m_pcode[k] = ec[k];
                end
            end else if (drained) begin
                m_pend[k] = 0;
            end
        end
    endtask

    // One clock: log a handshake, advance model, compare outputs on negedge
    task automatic step();
        ev_t e;
        if (!rst && ev_valid === 1'b1 && ev_ready === 1'b1) begin
            e.key  = int'(ev_key);
            e.code = int'(ev_code);
            e.cyc  = cyc;
            log_q.push_back(e);
            n_hs++;
        end
        @(posedge clk);
        m_step();
        cyc++;
        @(negedge clk);
        chk("ev_valid", ev_valid, m_valid);
        if (m_valid) begin
            chk("ev_key", ev_key, m_key);
            chk("ev_code", ev_code, m_code);
        end
        chk("key_down", key_down, m_down);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic settle(input int n);
        key_lvl  = '1;
        ev_ready = 1'b1;
        clr_ovf  = 1'b1;
        step();
        clr_ovf  = 1'b0;
        repeat (n) step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  nbad, dt, found, k;
        rst      = 1'b1;
        key_lvl  = '1;
        ev_ready = 1'b1;
        clr_ovf  = 1'b0;
        m_reset();
        step();
        step();
        chk("rst_valid", ev_valid, 0);
        chk("rst_key", ev_key, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_down", key_down, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        step();

        // Simultaneous presses: fresh priority starts at key 0
        key_lvl[0] = 1'b0;
        key_lvl[2] = 1'b0;
        step();
        step();
        chk("t2_v0", ev_valid, 1);
        chk("t2_key0", ev_key, 0);
        step();
        chk("t2_key2", ev_key, 2);
        key_lvl[1] = 1'b0;
        key_lvl[3] = 1'b0;
        step();
        step();
        chk("t2_key3", ev_key, 3);
        step();
        chk("t2_key1", ev_key, 1);
        settle(12);

        // Long hold on key 0
        log_q.delete();
        key_lvl[0] = 1'b0;
        repeat (40) step();
        key_lvl[0] = 1'b1;
        repeat (6) step();
        chk("t1_count_ok", (log_q.size() >= 4), 1);
        if (log_q.size() >= 4) begin
            chk("t1_press", log_q[0].code, 0);
            chk("t1_long", log_q[1].code, 1);
            dt = log_q[1].cyc - log_q[0].cyc;
            chk("t1_long_dt_ok", (dt >= 8 && dt <= 16), 1);
            chk("t1_release", log_q[log_q.size()-1].code, 3);
            nbad = 0;
            for (int i = 0; i < log_q.size(); i++) begin
                if (log_q[i].key != 0) nbad++;
                if (i >= 2 && i < log_q.size() - 1) begin
                    if (log_q[i].code != 2) nbad++;
                    if (log_q[i].cyc - log_q[i-1].cyc != REPEAT * TDIV) nbad++;
                end
            end
            chk("t1_repeat_seq_bad", nbad, 0);
        end
        chk("t1_ovf", ovf, 0);
        settle(4);

        // Key 1 with a stalled consumer: overflow on the re-press
        ev_ready   = 1'b0;
        key_lvl[1] = 1'b0;
        repeat (3) step();
        chk("t3_hold_key", ev_key, 1);
        chk("t3_hold_code", ev_code, 0);
        key_lvl[1] = 1'b1;
        repeat (2) step();
        key_lvl[1] = 1'b0;
        repeat (2) step();
        chk("t3_ovf_set", ovf[1], 1);
        log_q.delete();
        ev_ready = 1'b1;
        repeat (3) step();
        chk("t3_count_ok", (log_q.size() >= 2), 1);
        if (log_q.size() >= 2) begin
            chk("t3_ev0", {log_q[0].key[7:0], log_q[0].code[7:0]}, {8'd1, 8'd0});
            chk("t3_ev1", {log_q[1].key[7:0], log_q[1].code[7:0]}, {8'd1, 8'd3});
        end
        chk("t3_ovf_sticky", ovf[1], 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("t3_ovf_clr", ovf[1], 0);
        settle(6);

        // Release exactly on the tick that would produce LONG
        log_q.delete();
        key_lvl[0] = 1'b0;
        step();
        found = 0;
        for (int w = 0; w < 100 && found == 0; w++) begin
            if (m_down[0] && m_ticks[0] == LONG - 1 && m_presc == TDIV - 1) found = 1;
            else step();
        end
        chk("t4_found", found, 1);
        key_lvl[0] = 1'b1;
        step();
        chk("t4_kd", key_down[0], 0);
        repeat (4) step();
        chk("t4_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("t4_press", log_q[0].code, 0);
            chk("t4_release", log_q[1].code, 3);
        end
        settle(4);

        // Stalled output stays stable
        ev_ready   = 1'b0;
        key_lvl[3] = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_valid", ev_valid, 1);
            chk("t6_key", ev_key, 3);
            chk("t6_code", ev_code, 0);
        end
        settle(20);

        // Reset while key 2 has a REPEAT pending
        key_lvl[2] = 1'b0;
        found = 0;
        for (int w = 0; w < 200 && found == 0; w++) begin
            step();
            if (m_pend[2] && m_pcode[2] == 2) found = 1;
        end
        chk("t5_found", found, 1);
        rst = 1'b1;
        step();
        chk("t5_rst_valid", ev_valid, 0);
        chk("t5_rst_down", key_down, 0);
        chk("t5_rst_ovf", ovf, 0);
        chk("t5_rst_key", ev_key, 0);
        rst = 1'b0;
        step();
        chk("t5_v_early", ev_valid, 0);
        step();
        chk("t5_v", ev_valid, 1);
        chk("t5_key", ev_key, 2);
        chk("t5_code", ev_code, 0);
        settle(8);

        // Random key activity and consumer back-pressure
        n_hs = 0;
        for (int c = 0; c < 40000 && n_hs < 1000; c++) begin
            if ($urandom_range(5) == 0) begin
                k = $urandom_range(NK - 1);
                key_lvl[k] = ~key_lvl[k];
            end
            ev_ready = ($urandom_range(1) == 1);
            clr_ovf  = ($urandom_range(49) == 0);
            step();
        end
        chk("rand_events_ok", (n_hs >= 1000), 1);
        settle(20);
        chk("end_idle", ev_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Event controller behind the per-key debouncers.
- Takes NUM_KEYS debounced key levels (low = pressed) and runs a per-key press/long-press/auto-repeat state machine with a shared ms-tick prescaler.
- A round-robin arbiter serialises per-key events onto one valid/ready event port for the UI/menu logic.

Parameters:
NUM_KEYS, 4, number of debounced key inputs (1..8)
KEY_W, 2, width of ev_key; must satisfy 2**KEY_W >= NUM_KEYS
TICK_DIV, 50000, clk cycles per timing tick (1 ms at 50 MHz)
LONG_TICKS, 1000, ticks a key must stay down before LONG event
REPEAT_TICKS, 200, ticks between REPEAT events while held
TMR_W, 16, per-key tick timer width; must hold max(LONG_TICKS, REPEAT_TICKS)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
key_lvl  in  NUM_KEYS  debounced key levels, 0 = pressed
ev_valid  out  1  event available
ev_ready  in  1  consumer accepts event when ev_valid & ev_ready
ev_key  out  KEY_W  index of key that produced the event
ev_code  out  2  00 PRESS, 01 LONG, 10 REPEAT, 11 RELEASE
key_down  out  NUM_KEYS  1 while key FSM not IDLE
ovf  out  NUM_KEYS  sticky per-key event-loss flag
clr_ovf  in  1  clears all ovf bits, one-cycle pulse

Behaviour:
- Reset values: ev_valid=0, ev_key=0, ev_code=0, key_down=0, ovf=0. All FSMs IDLE, timers 0, pending flags 0, prescaler 0. prev_lvl = all 1s. rr_last = NUM_KEYS-1, so key 0 has first priority.
- Edge detect per key:
  - prev_lvl registered every clk.
  - press_edge = prev=1 & cur=0; release_edge = prev=0 & cur=1.
  - A key held through reset produces a PRESS right after reset deasserts.
- Prescaler:
  - Free-running 0..TICK_DIV-1.
  - tick = 1 for one cycle when count = TICK_DIV-1, then wraps to 0.
  - Not synchronised to presses, so LONG/REPEAT timing has up to 1 tick of jitter.
- Per-key FSM (states IDLE, DOWN, HOLD):
  - IDLE: press_edge -> DOWN, timer=0, emit PRESS.
  - DOWN: on tick, timer++. On the tick where timer = LONG_TICKS-1 -> HOLD, timer=0, emit LONG.
  - HOLD: on tick, timer++. On the tick where timer = REPEAT_TICKS-1 -> timer=0, emit REPEAT, stay in HOLD.
  - DOWN/HOLD: release_edge -> IDLE, timer=0, emit RELEASE.
  - Release has priority over a same-cycle timer expiry; only RELEASE is emitted.
- Pending slot (one per key: pend flag + 2-bit code), set on the edge an event is emitted.
  - If the slot is occupied and not drained that cycle:
    - new PRESS/LONG/REPEAT is dropped and ovf[i] set;
    - new RELEASE overwrites the slot and sets ovf[i].
  - A slot drained and refilled in the same cycle is not an overflow.
- ovf handling: clr_ovf clears all bits. A set event in the same cycle wins for that bit.
- Arbiter/output register:
  - Loads when ev_valid=0 or (ev_valid & ev_ready).
  - Grant goes to the first pending key searching rr_last+1, rr_last+2, ... modulo NUM_KEYS.
  - On load: ev_key/ev_code take the slot, that pend is cleared, rr_last = granted index.
  - No pending key at load time -> ev_valid=0.
  - While ev_valid=1 & ev_ready=0, ev_key/ev_code are held stable.
- Latency: key_lvl change sampled at edge k sets the pending slot at k; ev_valid=1 after edge k+1. Back-to-back events give sustained throughput of 1 event/clk.
- Reset mid-operation: discards pending and in-flight events, no RELEASE generated; behaves as the reset values above.

Test Plan:
- Params TICK_DIV=4, LONG_TICKS=3, REPEAT_TICKS=2, ev_ready=1. Hold key0 low ~40 clk, then release -> sequence: PRESS(0), LONG(0) after 3 ticks (12±4 clk), REPEAT(0) every 8 clk, RELEASE(0). key_down[0]=1 throughout hold. No ovf.
- Keys 0 and 2 pressed in the same cycle, ev_ready=1 -> PRESS key0 on cycle k+1, PRESS key2 on k+2. Then a simultaneous key1/key3 press after the key2 grant -> key3 first (rr_last=2), then key1.
- Sequence for key1 with ev_ready=0:
  - press key1 -> output holds PRESS(1);
  - release -> pending RELEASE;
  - press again -> PRESS dropped, ovf[1]=1.
  - Then ev_ready=1 -> PRESS(1), RELEASE(1) delivered; ovf[1] stays 1 until clr_ovf pulse -> 0.
- Release key0 on exactly the tick where DOWN timer = LONG_TICKS-1 -> only RELEASE(0), no LONG. key_down[0]=0 next cycle.
- Assert rst for 1 clk while key2 is in HOLD with a pending REPEAT:
  - all outputs return to reset values;
  - with key2 still low, PRESS(2) appears 2 clk after rst deasserts.
- Hold ev_ready=0 for 10 clk with ev_valid=1 -> ev_key/ev_code constant. Random ev_ready toggling over 1000 events -> no event duplicated or lost unless ovf is set.
